// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl -- fetch program-counter sequencer
//
// Holds the fetch PC and advances it every unstalled cycle according to the
// next-PC select coming from decode (sequential, taken branch, j/jal,
// jr/jalr). A misaligned jr/jalr target freezes the sequencer in HALT with a
// sticky error flag until reset.
//
// Ports
//   clk          in   1   system clock, rising-edge active
//   reset_n      in   1   asynchronous active-low reset
//   pc_op        in   2   next-PC select: 00 seq, 01 branch, 10 j/jal, 11 jr/jalr
//   pc_d         in  32   PC of the instruction in D stage (branch/jump base)
//   imm16        in  16   signed branch offset in words
//   instr_index  in  26   j/jal target field
//   rs_val       in  32   forwarded rs value for jr/jalr
//   stall        in   1   hazard stall, freezes the fetch PC
//   pc_f         out 32   current fetch PC
//   pc_valid     out  1   fetch address valid (RUN only)
//   redirect     out  1   one-cycle pulse after a non-sequential update
//   addr_err     out  1   sticky misaligned jr/jalr target flag
//   redirect_cnt out 16   saturating count of redirects
// -----------------------------------------------------------------------------
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  pc_op,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  input  logic        stall,
  output logic [31:0] pc_f,
  output logic        pc_valid,
  output logic        redirect,
  output logic        addr_err,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_f_q;
  logic        pc_valid_q;
  logic        redirect_q;
  logic        addr_err_q;
  logic [15:0] redirect_cnt_q;

  logic [31:0] seq_pc_d;
  logic [31:0] br_off_d;
  logic [31:0] next_pc_d;
  logic        jr_misaligned_d;
  logic [15:0] cnt_next_d;

  // Next-PC candidates, jr alignment check and saturating counter increment.
  always_comb begin
    seq_pc_d = pc_f_q + 32'd4;
    // Word offset sign-extended and scaled to bytes; sums wrap modulo 2^32.
    br_off_d = {{14{imm16[15]}}, imm16, 2'b00};
    case (pc_op)
      2'b00:   next_pc_d = seq_pc_d;
      2'b01:   next_pc_d = pc_d + 32'd4 + br_off_d;
      2'b10:   next_pc_d = {pc_d[31:28], instr_index, 2'b00};
      2'b11:   next_pc_d = rs_val;
      default: next_pc_d = seq_pc_d;
    endcase
    jr_misaligned_d = (pc_op == 2'b11) && (rs_val[1:0] != 2'b00);
    if (redirect_cnt_q == 16'hFFFF) begin
      cnt_next_d = redirect_cnt_q;
    end else begin
      cnt_next_d = redirect_cnt_q + 16'd1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= BOOT;
      pc_f_q         <= RESET_PC;
      pc_valid_q     <= 1'b0;
      redirect_q     <= 1'b0;
      addr_err_q     <= 1'b0;
      redirect_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        BOOT: begin
          // Leave BOOT unconditionally; stall is not looked at here.
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
          redirect_q <= 1'b0;
        end
        RUN: begin
          if (stall) begin
            redirect_q <= 1'b0;
          end else if (jr_misaligned_d) begin
            // Bad jr/jalr target: keep the PC and park until reset.
            state_q    <= HALT;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            addr_err_q <= 1'b1;
          end else begin
            pc_f_q     <= next_pc_d;
            redirect_q <= (pc_op != 2'b00);
            if (pc_op != 2'b00) begin
              redirect_cnt_q <= cnt_next_d;
            end else begin
              redirect_cnt_q <= redirect_cnt_q;
            end
          end
        end
        HALT: begin
          pc_valid_q <= 1'b0;
          redirect_q <= 1'b0;
          addr_err_q <= 1'b1;
        end
        default: begin
          // Unreachable encoding: recover as if freshly reset.
          state_q        <= BOOT;
          pc_f_q         <= RESET_PC;
          pc_valid_q     <= 1'b0;
          redirect_q     <= 1'b0;
          addr_err_q     <= 1'b0;
          redirect_cnt_q <= 16'd0;
        end
      endcase
    end
  end

  assign pc_f         = pc_f_q;
  assign pc_valid     = pc_valid_q;
  assign redirect     = redirect_q;
  assign addr_err     = addr_err_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_ctrl -- self-checking bench for pc_seq_ctrl
//
// Directed scenarios (boot, branch, jumps, stall, wrap, saturation, error and
// asynchronous reset) plus a randomized run, all compared every cycle against a
// behavioural model of the fetch PC sequencer kept in this file.
// -----------------------------------------------------------------------------
module tb_pc_seq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  pc_op;
  logic [31:0] pc_d;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic        stall;
  logic [31:0] pc_f;
  logic        pc_valid;
  logic        redirect;
  logic        addr_err;
  logic [15:0] redirect_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_booting;
  bit          m_halted;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_err;
  bit          m_redir;

  pc_seq_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_op        (pc_op),
    .pc_d         (pc_d),
    .imm16        (imm16),
    .instr_index  (instr_index),
    .rs_val       (rs_val),
    .stall        (stall),
    .pc_f         (pc_f),
    .pc_valid     (pc_valid),
    .redirect     (redirect),
    .addr_err     (addr_err),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_f"},         pc_f, m_pc);
    chk({tag, ".pc_valid"},     {31'd0, pc_valid}, {31'd0, (!m_booting && !m_halted)});
    chk({tag, ".redirect"},     {31'd0, redirect}, {31'd0, m_redir});
    chk({tag, ".addr_err"},     {31'd0, addr_err}, {31'd0, m_err});
    chk({tag, ".redirect_cnt"}, {16'd0, redirect_cnt}, 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_booting = 1'b1;
    m_halted  = 1'b0;
    m_pc      = 32'h0000_3000;
    m_cnt     = 0;
    m_err     = 1'b0;
    m_redir   = 1'b0;
  endtask

  // One rising edge of the model, using the inputs held across the edge.
  task automatic model_step();
    int off;
    m_redir = 1'b0;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_halted || stall) begin
      // nothing moves
    end else if (pc_op == 2'd3 && (rs_val % 32'd4) != 32'd0) begin
      m_halted = 1'b1;
      m_err    = 1'b1;
    end else begin
      case (pc_op)
        2'd0: m_pc = m_pc + 32'd4;
        2'd1: begin
          off  = int'($signed(imm16));
          m_pc = pc_d + 32'd4 + 32'(off * 4);
        end
        2'd2: m_pc = (pc_d & 32'hF000_0000) + 32'(instr_index) * 32'd4;
        default: m_pc = rs_val;
      endcase
      if (pc_op != 2'd0) begin
        m_redir = 1'b1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic [1:0] op, input logic st);
    pc_op = op;
    stall = st;
  endtask

  initial begin
    reset_n = 1'b0;
    pc_op = 2'd0; pc_d = 32'd0; imm16 = 16'd0; instr_index = 26'd0;
    rs_val = 32'd0; stall = 1'b0;
    model_reset();

    // Reset state, then boot sequence 3000, 3004, 3008
    #12;
    check_all("reset");
    reset_n = 1'b1;
    #1;
    check_all("boot_hold");
    cycle("boot_run");
    chk("boot_pc0", pc_f, 32'h0000_3000);
    cycle("seq1");
    chk("seq_pc1", pc_f, 32'h0000_3004);
    cycle("seq2");
    chk("seq_pc2", pc_f, 32'h0000_3008);

    // Backward branch
    pc_d = 32'h0000_3004; imm16 = 16'hFFFE; set_in(2'd1, 1'b0);
    cycle("branch");
    chk("branch_pc", pc_f, 32'h0000_3000);
    chk("branch_redir", {31'd0, redirect}, 32'd1);
    chk("branch_cnt", {16'd0, redirect_cnt}, 32'd1);
    set_in(2'd0, 1'b0);
    cycle("after_branch");

    // j then jr
    pc_d = 32'h0000_3010; instr_index = 26'h000_0C10; set_in(2'd2, 1'b0);
    cycle("jump");
    chk("jump_pc", pc_f, 32'h0000_3040);
    rs_val = 32'h0000_3100; set_in(2'd3, 1'b0);
    cycle("jr");
    chk("jr_pc", pc_f, 32'h0000_3100);
    chk("jr_cnt", {16'd0, redirect_cnt}, 32'd3);

    // Stall three cycles with a pending branch, then release
    pc_d = 32'h0000_3200; imm16 = 16'h0010; set_in(2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall_pc", pc_f, 32'h0000_3100);
    end
    set_in(2'd1, 1'b0);
    cycle("stall_release");
    chk("stall_rel_pc", pc_f, 32'h0000_3244);

    // Randomized traffic, aligned jr targets only
    for (int i = 0; i < 400; i++) begin
      pc_op       = 2'($urandom_range(0, 3));
      stall       = ($urandom_range(0, 3) == 0);
      pc_d        = $urandom;
      imm16       = 16'($urandom);
      instr_index = 26'($urandom);
      rs_val      = $urandom & 32'hFFFF_FFFC;
      cycle("rand");
    end

    // Wrap: sequential and negative branch offset
    rs_val = 32'hFFFF_FFFC; set_in(2'd3, 1'b0);
    cycle("wrap_jr");
    set_in(2'd0, 1'b0);
    cycle("wrap_seq");
    chk("wrap_seq_pc", pc_f, 32'h0000_0000);
    pc_d = 32'h0000_0000; imm16 = 16'hFFFE; set_in(2'd1, 1'b0);
    cycle("wrap_br");
    chk("wrap_br_pc", pc_f, 32'hFFFF_FFFC);

    // Saturation: 65536 more redirects
    pc_d = 32'h1234_5678; instr_index = 26'h000_0100; set_in(2'd2, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      cycle("sat");
    end
    chk("sat_cnt", {16'd0, redirect_cnt}, 32'h0000_FFFF);

    // Mid-RUN asynchronous reset
    set_in(2'd1, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("run_reset");
    #1;
    reset_n = 1'b1;
    set_in(2'd0, 1'b1);
    cycle("boot2");
    set_in(2'd0, 1'b0);
    cycle("boot2_seq");

    // Misaligned jr: halt with sticky error
    rs_val = 32'h0000_3102; set_in(2'd3, 1'b0);
    cycle("err");
    chk("err_flag", {31'd0, addr_err}, 32'd1);
    chk("err_pc", pc_f, 32'h0000_3004);
    for (int i = 0; i < 4; i++) begin
      pc_op = 2'($urandom_range(0, 3));
      stall = 1'($urandom_range(0, 1));
      rs_val = $urandom & 32'hFFFF_FFFC;
      cycle("halt");
    end

    // Reset out of HALT, before the next edge
    @(posedge clk);
    model_step();
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("halt_reset");
    chk("halt_reset_pc", pc_f, 32'h0000_3000);
    #1;
    reset_n = 1'b1;
    set_in(2'd0, 1'b0);
    cycle("boot3");
    cycle("boot3_seq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
